// File: rtl/channel_scheduler_if.sv
// Requester/channel bus of channel_scheduler: request, data and accept strobes in,
// registered channel word out. The scheduler takes the slave modport.
interface channel_scheduler_if #(
  parameter int DATA_W = 16
);
  logic [2:0]          req;
  logic [3*DATA_W-1:0] data_in;
  logic [2:0]          ack;
  logic [DATA_W-1:0]   ch_data;
  logic                ch_valid;
  logic [1:0]          ch_src;
  logic                busy;

  modport master (
    output req, data_in,
    input  ack, ch_data, ch_valid, ch_src, busy
  );

  modport slave (
    input  req, data_in,
    output ack, ch_data, ch_valid, ch_src, busy
  );
endinterface

// File: rtl/channel_scheduler.sv
// Three-requester burst scheduler feeding one channel (IDLE -> XFER -> GAP).
// Define CH_SCHED_PRIO_EN for fixed priority 0 > 1 > 2; default build is round-robin.
module channel_scheduler #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                clk_50,
  input  logic                reset,
  channel_scheduler_if.slave  bus,
  output logic [1:0]          dbg_state,
  output logic [1:0]          dbg_rr
);
  // Handshake: a word moves when ack[i] is high (XFER, grant = i, req[i] = 1);
  // it appears on ch_data with ch_valid = 1 one cycle later, otherwise ch_valid = 0.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [3:0] BURST_END = 4'(BURST_LEN);

  state_t            state;
  logic [1:0]        grant;
  logic [3:0]        beat;
  logic [3:0]        beat_next;
  logic [1:0]        winner;
  logic [1:0]        rr_after;
  logic              accept;
  logic [DATA_W-1:0] word;

`ifdef CH_SCHED_PRIO_EN
  always_comb begin
    winner = 2'd2;
    if (bus.req[1]) winner = 2'd1;
    if (bus.req[0]) winner = 2'd0;
  end

  assign dbg_rr = 2'd0;
`else
  logic [1:0] rr;
  logic [2:0] cand;
  logic       found;

  // Scan from rr upward, wrapping after requester 2.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    cand   = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = 3'(rr) + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!found && bus.req[cand[1:0]]) begin
        winner = cand[1:0];
        found  = 1'b1;
      end
    end
  end

  assign dbg_rr = rr;
`endif

  assign rr_after  = (grant == 2'd2) ? 2'd0 : grant + 2'd1;
  assign accept    = (state == XFER) && bus.req[grant];
  assign beat_next = beat + 4'd1;
  assign word      = bus.data_in[int'(grant)*DATA_W +: DATA_W];
  assign bus.ack   = accept ? (3'b001 << grant) : 3'b000;
  assign dbg_state = state;

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= 2'd0;
      beat         <= 4'd0;
      bus.ch_data  <= '0;
      bus.ch_valid <= 1'b0;
      bus.ch_src   <= 2'd0;
      bus.busy     <= 1'b0;
`ifndef CH_SCHED_PRIO_EN
      rr           <= 2'd0;
`endif
    end else begin
      bus.ch_valid <= accept;
      if (accept) begin
        bus.ch_data <= word;
        bus.ch_src  <= grant;
      end
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= XFER;
            grant    <= winner;
            beat     <= 4'd0;
            bus.busy <= 1'b1;
          end
        end
        XFER: begin
          if (accept) beat <= beat_next;
          // A dropped request ends the burst early without moving a word.
          if (!accept || beat_next == BURST_END) begin
            state <= GAP;
`ifndef CH_SCHED_PRIO_EN
            rr    <= rr_after;
`endif
          end
        end
        GAP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef CH_SCHED_PRIO_EN
  logic unused_rr_after;
  assign unused_rr_after = ^rr_after;
`endif
endmodule

// File: tb/tb_channel_scheduler.sv
// Bench for channel_scheduler: directed scenarios plus random requests checked
// against a transaction-level model of grants, bursts and the channel word stream.
module tb_channel_scheduler;
  localparam int DW = 16;
  localparam int BL = 4;

  // clock / reset
  logic clk_50 = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_50 = ~clk_50;

  channel_scheduler_if #(.DATA_W(DW)) bus ();
  channel_scheduler_if #(.DATA_W(DW)) bus1 ();
  logic [1:0] dbg_state, dbg_rr, dbg_state1, dbg_rr1;

  channel_scheduler #(.DATA_W(DW), .BURST_LEN(BL)) u_dut (
    .clk_50    (clk_50),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_rr    (dbg_rr)
  );

  channel_scheduler #(.DATA_W(DW), .BURST_LEN(1)) u_dut1 (
    .clk_50    (clk_50),
    .reset     (reset),
    .bus       (bus1.slave),
    .dbg_state (dbg_state1),
    .dbg_rr    (dbg_rr1)
  );

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;

  // scoreboard: {src, data} of words accepted last cycle
  logic [DW+1:0] exp_q[$];

  // reference model: burst owner (-1 = none), cooldown cycles, round-robin start
  int          m_owner = -1;
  int          m_cool  = 0;
  int          m_start = 0;
  int          m_words = 0;
  logic [2:0]  m_ack   = 3'b000;
  logic        m_busy  = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [1:0]    m_src  = 2'd0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] r);
`ifdef CH_SCHED_PRIO_EN
    for (int k = 0; k < 3; k++) if (r[k]) return k;
`else
    for (int k = 0; k < 3; k++) if (r[(m_start + k) % 3]) return (m_start + k) % 3;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_cool  = 0;
    m_start = 0;
    m_words = 0;
    m_ack   = 3'b000;
    m_busy  = 1'b0;
    m_data  = '0;
    m_src   = 2'd0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [2:0] r, input logic [3*DW-1:0] d);
    m_ack = 3'b000;
    if (m_owner >= 0) begin
      if (r[m_owner]) begin
        m_ack[m_owner] = 1'b1;
        exp_q.push_back({2'(m_owner), d[m_owner*DW +: DW]});
        m_words++;
      end
      if (!r[m_owner] || m_words == BL) begin
        m_start = (m_owner + 1) % 3;
        m_owner = -1;
        m_cool  = 1;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (r != 3'b000) begin
      m_owner = pick(r);
      m_words = 0;
    end
    m_busy = (m_owner >= 0) || (m_cool > 0);
  endtask

  task automatic check_regs();
    logic [DW+1:0] item;
    logic          exp_v;
    exp_v = 1'b0;
    if (exp_q.size() > 0) begin
      item   = exp_q.pop_front();
      m_src  = item[DW+1:DW];
      m_data = item[DW-1:0];
      exp_v  = 1'b1;
    end
    check("ch_valid", bus.ch_valid, exp_v);
    check("ch_data", bus.ch_data, m_data);
    check("ch_src", bus.ch_src, m_src);
    check("busy", bus.busy, m_busy);
    if (bus.ch_valid === 1'b1) vcount++;
  endtask

  // driver: one clock cycle of requester stimulus
  task automatic cycle(input logic [2:0] r, input logic [3*DW-1:0] d);
    @(negedge clk_50);
    check_regs();
    bus.req     = r;
    bus.data_in = d;
    #1;
    model_step(r, d);
    check("ack", bus.ack, m_ack);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ch_data"}, bus.ch_data, 0);
    check({tag, "_ch_valid"}, bus.ch_valid, 0);
    check({tag, "_ch_src"}, bus.ch_src, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_ack"}, bus.ack, 0);
    check({tag, "_rr"}, dbg_rr, 0);
  endtask

  task automatic do_reset();
    @(negedge clk_50);
    reset    = 1'b0;
    bus.req  = 3'b000;
    bus1.req = 3'b000;
    #1;
    check_zero("reset");
    model_reset();
    repeat (2) @(negedge clk_50);
    reset = 1'b1;
  endtask

  function automatic logic [3*DW-1:0] rand_data();
    return {16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  int         first_src[8];
  int         n;
  int         k;
  logic       prev_v;
  logic [2:0] r;
  logic [DW-1:0] w;

  initial begin
    bus.req      = 3'b000;
    bus.data_in  = '0;
    bus1.req     = 3'b000;
    bus1.data_in = '0;

    do_reset();

    // single requester streaming a constant word
    vcount = 0;
    for (int i = 0; i < 14; i++) cycle(3'b001, {16'd0, 16'd0, 16'd43224});
    check("single_req_words", vcount, 8);

    // all requesting: burst owners in arbitration order
    do_reset();
    n = 0;
    prev_v = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(3'b111, rand_data());
      if (bus.ch_valid === 1'b1 && prev_v !== 1'b1 && n < 8) begin
        first_src[n] = int'(bus.ch_src);
        n++;
      end
      prev_v = bus.ch_valid;
    end
    check("all_req_bursts", (n >= 4), 1);
    check("burst0_src", first_src[0], 0);
`ifdef CH_SCHED_PRIO_EN
    check("burst1_src", first_src[1], 0);
    check("burst2_src", first_src[2], 0);
`else
    check("burst1_src", first_src[1], 1);
    check("burst2_src", first_src[2], 2);
`endif
    check("burst3_src", first_src[3], 0);

    // requester 1 drops its request after two words
    do_reset();
    vcount = 0;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      r = (k < 2) ? 3'b010 : 3'b000;
      w = (k == 0) ? 16'd34232 : 16'd15423;
      cycle(r, {16'd0, w, 16'd0});
      if (m_ack[1]) k++;
    end
    check("drop_words", vcount, 2);
`ifdef CH_SCHED_PRIO_EN
    check("drop_rr", dbg_rr, 0);
`else
    check("drop_rr", dbg_rr, 2);
`endif

    // reset on the third beat of a burst
    do_reset();
    k = 0;
    for (int i = 0; i < 12 && k < 3; i++) begin
      cycle(3'b111, rand_data());
      if (m_ack != 3'b000) k++;
    end
    check("third_beat_reached", k, 3);
    reset   = 1'b0;
    bus.req = 3'b000;
    #1;
    check_zero("mid_reset");
    model_reset();
    @(negedge clk_50);
    reset = 1'b1;
    n = 3;
    for (int i = 0; i < 8; i++) begin
      cycle(3'b111, rand_data());
      if (bus.ch_valid === 1'b1 && n == 3) n = int'(bus.ch_src);
    end
    check("first_grant_after_reset", n, 0);

    // single-word bursts on the BURST_LEN = 1 instance
    for (int i = 0; i < 8; i++) first_src[i] = -1;
    n = 0;
    bus1.req = 3'b110;
    for (int i = 0; i < 30; i++) begin
      bus1.data_in = rand_data();
      cycle(3'b000, rand_data());
      if (bus1.ch_valid === 1'b1 && n < 8) begin
        first_src[n] = int'(bus1.ch_src);
        n++;
      end
    end
    bus1.req = 3'b000;
    check("bl1_words", (n >= 4), 1);
    check("bl1_src0", first_src[0], 1);
`ifdef CH_SCHED_PRIO_EN
    check("bl1_src1", first_src[1], 1);
    check("bl1_src2", first_src[2], 1);
`else
    check("bl1_src1", first_src[1], 2);
    check("bl1_src2", first_src[2], 1);
`endif

    // random request patterns against the model
    r = 3'b000;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
      cycle(r, rand_data());
    end
    cycle(3'b000, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
